booth_r4: RTL and testbench
===========================

BOOTH_R4 -- requirements
Module: booth_r4

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 x_in  input  8  multiplier operand, two's-complement signed.
REQ-005 in_valid  input  1  x_in is sampled when high at a rising clk edge.
REQ-006 y_out  output  12  four Booth radix-4 digits, 3 bits each, digit 0 in y_out[2:0], digit i in y_out[3i+2:3i].
REQ-007 out_valid  output  1  y_out holds the encoding of a sampled x_in.
REQ-008 recon_out  output  8  present only with BOOTH_R4_CHECK_EN; signed value reconstructed from the registered digits.

Function
REQ-009 Digit i (i=0..3) SHALL be encoded from the triplet {x[2i+1], x[2i], x[2i-1]}, with x[-1]=0.
REQ-010 Each digit field SHALL be {neg, two, one}, with two and one mutually exclusive.
REQ-011 Triplet mapping SHALL be: 000->0 {000}; 001->+1 {001}; 010->+1 {001}; 011->+2 {010}; 100->-2 {110}; 101->-1 {101}; 110->-1 {101}; 111->0 {000}.
REQ-012 A zero digit SHALL always be 000; neg SHALL never be set with two=one=0.
REQ-013 The digit sum d0 + 4*d1 + 16*d2 + 64*d3 SHALL equal signed x_in for all 256 inputs, including -128 and +127.
REQ-014 Latency SHALL be 1 cycle: when in_valid=1 at edge N, y_out and out_valid=1 are valid after edge N.
REQ-015 When in_valid=0 at an edge, y_out SHALL hold its previous value and out_valid SHALL go to 0.
REQ-016 Back-to-back in_valid SHALL be accepted every cycle; there is no backpressure.

Reset
REQ-017 While reset=1 at an edge, y_out SHALL become 12'h000, out_valid 0 and recon_out 0; reset has priority over in_valid.
REQ-018 An input presented in a reset cycle SHALL be dropped; the first valid output follows the first in_valid=1 edge after reset deasserts.

Configuration
REQ-019 With BOOTH_R4_CHECK_EN defined, recon_out SHALL be registered with y_out and SHALL equal the REQ-013 sum of the digits in y_out (8-bit signed).
REQ-020 With BOOTH_R4_CHECK_EN undefined, the recon_out port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-021 Package booth_r4_pkg SHALL hold NUM_DIGITS=4, DIGIT_W=3, IN_W=8, and the digit struct typedef {neg, two, one}.
REQ-022 Sub-module booth_r4_digit_enc SHALL be purely combinational (3-bit triplet -> digit struct) and SHALL be instantiated four times.

Verification
REQ-023 x_in=8'h00, in_valid=1 -> next cycle y_out=12'h000, out_valid=1.
REQ-024 x_in=8'hFF (-1) -> y_out=12'h005; x_in=8'h7F (+127) -> y_out=12'h405.
REQ-025 x_in=8'h80 (-128) -> y_out=12'hC00; x_in=8'h55 (+85) -> y_out=12'h249; x_in=8'hAA (-86) -> y_out=12'hB6E.
REQ-026 Back-to-back sequence 8'h55, then in_valid=0, then reset=1 for one cycle:
- after the 8'h55 edge: y_out=12'h249, out_valid=1;
- after the idle edge: y_out=12'h249, out_valid=0;
- after the reset edge: y_out=12'h000, out_valid=0.
REQ-027 Exhaustive sweep of all 256 x_in values:
- the digit sum equals signed x_in;
- no field is 100, 011 or 111;
- with BOOTH_R4_CHECK_EN defined, recon_out equals x_in.

Source files
------------

// File: rtl/booth_r4_pkg.sv
// Shared constants, the Booth digit struct and a digit-to-value helper for booth_r4.
// Optional BOOTH_R4_CHECK_EN build adds a reconstructed-value output.
package booth_r4_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 3;
    localparam int IN_W       = 8;
    localparam int OUT_W      = NUM_DIGITS * DIGIT_W;

    // Field order matches the y_out layout: {neg, two, one}.
    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } digit_t;

    function automatic logic signed [2:0] digit_value(input digit_t d);
        logic signed [2:0] mag;
        mag = d.two ? 3'sd2 : (d.one ? 3'sd1 : 3'sd0);
        return d.neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/booth_r4_if.sv
// Operand/result bundle for booth_r4. slave = the encoder, master = whoever feeds it.
// recon_out exists only when BOOTH_R4_CHECK_EN is defined.
interface booth_r4_if;
    import booth_r4_pkg::*;

    // Valid-only stream, no backpressure: x_in is taken on every edge with
    // in_valid=1; out_valid=1 for exactly one cycle per accepted x_in.
    logic [IN_W-1:0]  x_in;
    logic             in_valid;
    logic [OUT_W-1:0] y_out;
    logic             out_valid;
`ifdef BOOTH_R4_CHECK_EN
    logic [IN_W-1:0]  recon_out;

    modport slave  (input x_in, in_valid, output y_out, out_valid, recon_out);
    modport master (output x_in, in_valid, input y_out, out_valid, recon_out);
`else
    modport slave  (input x_in, in_valid, output y_out, out_valid);
    modport master (output x_in, in_valid, input y_out, out_valid);
`endif

endinterface

// File: rtl/booth_r4_digit_enc.sv
// Combinational radix-4 Booth digit encoder: triplet {x[2i+1], x[2i], x[2i-1]} -> {neg, two, one}.
module booth_r4_digit_enc
    import booth_r4_pkg::*;
(
    input  logic [2:0] triplet,
    output digit_t     digit
);

    // 000 and 111 both encode zero, so neg is never set on a zero digit.
    always_comb begin
        digit = '0;
        case (triplet)
            3'b001, 3'b010: digit = '{neg: 1'b0, two: 1'b0, one: 1'b1};
            3'b011:         digit = '{neg: 1'b0, two: 1'b1, one: 1'b0};
            3'b100:         digit = '{neg: 1'b1, two: 1'b1, one: 1'b0};
            3'b101, 3'b110: digit = '{neg: 1'b1, two: 1'b0, one: 1'b1};
            default:        digit = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4.sv
// Registered radix-4 Booth recoder of an 8-bit signed operand into four {neg,two,one} digits.
// Define BOOTH_R4_CHECK_EN to also register the value reconstructed from the digits.
module booth_r4
    import booth_r4_pkg::*;
(
    input  logic clk,
    input  logic reset,
    booth_r4_if.slave bus
);

    // x[-1] is the implicit zero below the LSB.
    logic [IN_W:0]    x_ext;
    digit_t           digits [NUM_DIGITS];
    logic [OUT_W-1:0] y_next;

    assign x_ext = {bus.x_in, 1'b0};

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        booth_r4_digit_enc u_enc (
            .triplet (x_ext[2*i +: 3]),
            .digit   (digits[i])
        );
        assign y_next[DIGIT_W*i +: DIGIT_W] = digits[i];
    end

`ifdef BOOTH_R4_CHECK_EN
    // Sum wraps mod 256, which is exact because the true sum always fits in 8 signed bits.
    logic signed [IN_W-1:0] recon_next;

    always_comb begin
        recon_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            recon_next = recon_next + (IN_W'(digit_value(digits[i])) <<< (2 * i));
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.y_out     <= '0;
            bus.out_valid <= 1'b0;
`ifdef BOOTH_R4_CHECK_EN
            bus.recon_out <= '0;
`endif
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.y_out <= y_next;
`ifdef BOOTH_R4_CHECK_EN
                bus.recon_out <= recon_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_booth_r4.sv
// Self-checking bench for booth_r4: directed vectors, reset behaviour, exhaustive and random sweeps.
// Also checks recon_out when built with BOOTH_R4_CHECK_EN.
module tb_booth_r4;
    import booth_r4_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [OUT_W-1:0] exp_q [$];
    logic [IN_W-1:0]  x_q   [$];
    logic [OUT_W-1:0] exp_hold;

    booth_r4_if bus ();

    booth_r4 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Booth digit value d_i = -2*x[2i+1] + x[2i] + x[2i-1], then mapped to the field code.
    function automatic logic [OUT_W-1:0] model_y(input logic [IN_W-1:0] x);
        logic [IN_W:0]    xe;
        logic [OUT_W-1:0] r;
        int               d;
        logic [2:0]       f;
        xe = {x, 1'b0};
        r  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = -2 * int'(xe[2*i+2]) + int'(xe[2*i+1]) + int'(xe[2*i]);
            case (d)
                1:       f = 3'b001;
                2:       f = 3'b010;
                -1:      f = 3'b101;
                -2:      f = 3'b110;
                default: f = 3'b000;
            endcase
            r[3*i +: 3] = f;
        end
        return r;
    endfunction

    function automatic int decode_sum(input logic [OUT_W-1:0] y);
        int s;
        int v;
        logic [2:0] f;
        s = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            f = y[3*i +: 3];
            v = f[1] ? 2 : (f[0] ? 1 : 0);
            if (f[2]) v = -v;
            s += v * (1 << (2 * i));
        end
        return s;
    endfunction

    // ---------------- driver / scoreboard ----------------
    task automatic step(input logic [IN_W-1:0] x, input logic v, input logic r);
        logic [OUT_W-1:0] e;
        logic [IN_W-1:0]  xs;
        logic [2:0]       f;
        bus.x_in     = x;
        bus.in_valid = v;
        reset        = r;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            x_q.delete();
            exp_hold = '0;
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_y_out", 32'(bus.y_out), 32'd0);
`ifdef BOOTH_R4_CHECK_EN
            check("rst_recon_out", 32'(bus.recon_out), 32'd0);
`endif
        end else begin
            if (v) begin
                exp_q.push_back(model_y(x));
                x_q.push_back(x);
            end
            check("out_valid", 32'(bus.out_valid), 32'(v));
            if (v && exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                xs = x_q.pop_front();
                exp_hold = e;
                check("y_out", 32'(bus.y_out), 32'(e));
                check("digit_sum", 32'(decode_sum(bus.y_out)), 32'(int'($signed(xs))));
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    f = bus.y_out[3*i +: 3];
                    check("field_legal", 32'(f == 3'b100 || f == 3'b011 || f == 3'b111), 32'd0);
                end
`ifdef BOOTH_R4_CHECK_EN
                check("recon_out", 32'(bus.recon_out), 32'(xs));
`endif
            end else begin
                check("y_hold", 32'(bus.y_out), 32'(exp_hold));
            end
        end
    endtask

    task automatic directed(input logic [IN_W-1:0] x, input logic [OUT_W-1:0] y_const);
        step(x, 1'b1, 1'b0);
        check("y_directed", 32'(bus.y_out), 32'(y_const));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        exp_hold     = '0;
        bus.x_in     = '0;
        bus.in_valid = 1'b0;
        reset        = 1'b1;

        // Reset with a valid input present: the input must be dropped.
        step(8'h55, 1'b1, 1'b1);
        step(8'h3C, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0);

        directed(8'h00, 12'h000);
        directed(8'hFF, 12'h005);
        directed(8'h7F, 12'h405);
        directed(8'h80, 12'hC00);
        directed(8'h55, 12'h249);
        directed(8'hAA, 12'hB6E);

        // Valid, idle, then reset.
        directed(8'h55, 12'h249);
        step(8'h12, 1'b0, 1'b0);
        check("seq_idle_y", 32'(bus.y_out), 32'h249);
        step(8'h34, 1'b1, 1'b1);
        check("seq_rst_y", 32'(bus.y_out), 32'h000);

        // Exhaustive sweep, back-to-back with occasional random idle cycles.
        for (int k = 0; k < 256; k++) begin
            if ($urandom_range(0, 3) == 0)
                step(8'($urandom_range(0, 255)), 1'b0, 1'b0);
            step(8'(k), 1'b1, 1'b0);
        end

        // Random traffic with random valid and rare resets.
        for (int k = 0; k < 300; k++) begin
            step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 40) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
